moore_seq_tx: RTL and testbench

Serial pattern transmitter that generates the `din`/`valid` bitstream consumed by the `moore_overlap` sequence detector. A parallel word is accepted over a load/ready handshake, serialized MSB-first, and optionally repeated with a programmable idle gap between copies. It sits upstream of the detector as a deterministic stimulus source and link-side transmitter.

---
 rtl/moore_seq_tx.sv | 124 ++++++++++++
 tb/tb_moore_seq_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_tx.sv
// Serial pattern transmitter: accepts a parallel word over load/ready, shifts it out MSB-first
// and optionally repeats it with a programmable idle gap between copies.
module moore_seq_tx #(
  parameter int W   = 8,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic [3:0]   rpt,
  output logic         ready,
  output logic         dout,
  output logic         valid,
  output logic         done,
  output logic [15:0]  frames
);

  localparam int BW = $clog2(W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t          r_state,  w_state;
  logic [W-1:0]    r_shreg,  w_shreg;
  logic [W-1:0]    r_hold,   w_hold;
  logic [BW-1:0]   r_bitCnt, w_bitCnt;
  logic [3:0]      r_copies, w_copies;
  logic [GW-1:0]   r_gapCnt, w_gapCnt;
  logic [15:0]     r_frames, w_frames;
  logic            w_lastBit;
  logic            w_lastCopy;

  assign w_lastBit  = (r_bitCnt == '0);
  assign w_lastCopy = (r_copies == 4'd1);

  // Outputs are pure decodes of registered state, so they are glitch-free relative to the clock.
  assign ready  = (r_state == S_IDLE);
  assign valid  = (r_state == S_SHIFT);
  assign dout   = valid & r_shreg[W-1];
  assign done   = valid & w_lastBit & w_lastCopy;
  assign frames = r_frames;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_hold   <= '0;
      r_bitCnt <= '0;
      r_copies <= '0;
      r_gapCnt <= '0;
      r_frames <= '0;
    end else begin
      r_state  <= w_state;
      r_shreg  <= w_shreg;
      r_hold   <= w_hold;
      r_bitCnt <= w_bitCnt;
      r_copies <= w_copies;
      r_gapCnt <= w_gapCnt;
      r_frames <= w_frames;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_shreg  = r_shreg;
    w_hold   = r_hold;
    w_bitCnt = r_bitCnt;
    w_copies = r_copies;
    w_gapCnt = r_gapCnt;
    w_frames = r_frames;

    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_shreg  = data;
          w_hold   = data;
          w_bitCnt = BW'(W - 1);
          w_copies = (rpt == 4'd0) ? 4'd1 : rpt;
          w_state  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_shreg  = {r_shreg[W-2:0], 1'b0};
        w_bitCnt = r_bitCnt - 1'b1;
        if (w_lastBit) begin
          if (r_frames != 16'hFFFF) begin
            w_frames = r_frames + 16'd1;
          end
          if (w_lastCopy) begin
            w_state = S_IDLE;
          end else begin
            // Reload from the hold copy so data changes after acceptance never leak into repeats.
            w_copies = r_copies - 4'd1;
            w_shreg  = r_hold;
            w_bitCnt = BW'(W - 1);
            if (GAP > 0) begin
              w_gapCnt = GW'(GAP - 1);
              w_state  = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        if (r_gapCnt == '0) begin
          w_state = S_SHIFT;
        end else begin
          w_gapCnt = r_gapCnt - 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_moore_seq_tx.sv
// Scoreboard bench for moore_seq_tx: one instance with GAP=0 and one with GAP=2.
// Stimulus pushes expected bits; per-instance monitors pop and compare on every valid cycle.
module tb_moore_seq_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load0 = 1'b0, load1 = 1'b0;
  logic [7:0]  data0 = '0, data1 = '0;
  logic [3:0]  rpt0 = '0, rpt1 = '0;
  logic        ready0, dout0, valid0, done0;
  logic        ready1, dout1, valid1, done1;
  logic [15:0] frames0, frames1;

  always #5 clk = ~clk;

  moore_seq_tx #(.W(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .load(load0), .data(data0), .rpt(rpt0),
    .ready(ready0), .dout(dout0), .valid(valid0), .done(done0), .frames(frames0)
  );

  moore_seq_tx #(.W(8), .GAP(2)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .data(data1), .rpt(rpt1),
    .ready(ready1), .dout(dout1), .valid(valid1), .done(done1), .frames(frames1)
  );

  // gap = idle cycles expected right before this bit; -1 for the first bit of a job.
  typedef struct {
    logic dBit;
    logic dDone;
    int   gap;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  item_t it0, it1;
  int    checks = 0;
  int    passes = 0;
  int    idle0 = 0;
  int    idle1 = 0;
  int    expFrames0 = 0;
  int    expFrames1 = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic scoreBit(input string tag, input item_t it, input logic d, input logic dn, input int idle);
    checkOutput({tag, " dout"}, int'(d), int'(it.dBit));
    checkOutput({tag, " done"}, int'(dn), int'(it.dDone));
    if (it.gap >= 0) checkOutput({tag, " gap"}, idle, it.gap);
  endtask

  // Monitors sample on the falling edge, away from the active clock edge.
  always @(negedge clk) begin
    if (!rst) idle0 = 0;
    else if (valid0) begin
      if (q0.size() == 0) checkOutput("dut0 queue", q0.size(), 1);
      else begin
        it0 = q0.pop_front();
        scoreBit("dut0", it0, dout0, done0, idle0);
      end
      idle0 = 0;
    end else begin
      checkOutput("dut0 idle outputs", int'({dout0, done0}), 0);
      idle0++;
    end
  end

  always @(negedge clk) begin
    if (!rst) idle1 = 0;
    else if (valid1) begin
      if (q1.size() == 0) checkOutput("dut1 queue", q1.size(), 1);
      else begin
        it1 = q1.pop_front();
        scoreBit("dut1", it1, dout1, done1, idle1);
      end
      idle1 = 0;
    end else begin
      checkOutput("dut1 idle outputs", int'({dout1, done1}), 0);
      idle1++;
    end
  end

  function automatic int getReady(input int w);
    return (w == 0) ? int'(ready0) : int'(ready1);
  endfunction

  function automatic int getValid(input int w);
    return (w == 0) ? int'(valid0) : int'(valid1);
  endfunction

  function automatic int getDone(input int w);
    return (w == 0) ? int'(done0) : int'(done1);
  endfunction

  function automatic int getFrames(input int w);
    return (w == 0) ? int'(frames0) : int'(frames1);
  endfunction

  function automatic int copiesOf(input logic [3:0] r);
    return (r == 4'd0) ? 1 : int'(r);
  endfunction

  // Called #1 after a rising edge; returns #1 after the acceptance edge (first bit on the wire).
  task automatic startJob(input int w, input logic [7:0] d, input logic [3:0] r);
    int    n, g, cyc;
    item_t it;
    n   = copiesOf(r);
    g   = (w == 0) ? 0 : 2;
    cyc = 0;
    while (getReady(w) == 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("ready before load", getReady(w), 1);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 8; i++) begin
        it.dBit  = d[7-i];
        it.dDone = (c == n - 1) && (i == 7);
        it.gap   = (c == 0 && i == 0) ? -1 : ((i == 0) ? g : 0);
        if (w == 0) q0.push_back(it);
        else q1.push_back(it);
      end
    end
    if (w == 0) begin
      expFrames0 += n;
      load0 = 1'b1; data0 = d; rpt0 = r;
    end else begin
      expFrames1 += n;
      load1 = 1'b1; data1 = d; rpt1 = r;
    end
    @(posedge clk); #1;
    load0 = 1'b0;
    load1 = 1'b0;
    checkOutput("first bit latency", getValid(w), 1);
    checkOutput("ready drops", getReady(w), 0);
  endtask

  // span is the 1-based index of the bit cycle currently on the wire.
  task automatic finishJob(input int w, input int n, input int startSpan);
    int span, g;
    span = startSpan;
    g    = (w == 0) ? 0 : 2;
    while (getDone(w) == 0 && span < 200) begin
      @(posedge clk); #1;
      span++;
    end
    checkOutput("first-to-last span", span, n * 8 + (n - 1) * g);
    @(posedge clk); #1;
    checkOutput("ready after done", getReady(w), 1);
    checkOutput("valid after done", getValid(w), 0);
    checkOutput("frames", getFrames(w), (w == 0) ? expFrames0 : expFrames1);
    checkOutput("queue drained", (w == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic applyStimulus(input int w, input logic [7:0] d, input logic [3:0] r);
    startJob(w, d, r);
    finishJob(w, copiesOf(r), 1);
  endtask

  task automatic checkResetState();
    checkOutput("reset ready0", int'(ready0), 1);
    checkOutput("reset valid0", int'(valid0), 0);
    checkOutput("reset dout0", int'(dout0), 0);
    checkOutput("reset done0", int'(done0), 0);
    checkOutput("reset frames0", int'(frames0), 0);
    checkOutput("reset ready1", int'(ready1), 1);
    checkOutput("reset valid1", int'(valid1), 0);
    checkOutput("reset dout1", int'(dout1), 0);
    checkOutput("reset done1", int'(done1), 0);
    checkOutput("reset frames1", int'(frames1), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    rst = 1'b1;

    // Single word, back-to-back with an ignored-load job.
    applyStimulus(0, 8'hB4, 4'd1);

    startJob(0, 8'hB4, 4'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    load0 = 1'b1; data0 = 8'h00; rpt0 = 4'd1;
    @(posedge clk); #1;
    load0 = 1'b0;
    finishJob(0, 1, 4);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("no extra frame", int'(frames0), expFrames0);

    // rpt=0 sends one copy; rpt=2 with GAP=0 has no bubble between copies.
    applyStimulus(0, 8'hFF, 4'd0);
    applyStimulus(0, 8'hA5, 4'd2);

    // Repeats with a 2-cycle gap.
    applyStimulus(1, 8'h0D, 4'd3);

    // Abort at bit 4 of a two-copy job, then restart immediately.
    startJob(1, 8'h0D, 4'd2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checkResetState();
    end
    q1.delete();
    expFrames0 = 0;
    expFrames1 = 0;
    rst = 1'b1;
    applyStimulus(1, 8'h3C, 4'd1);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
